// File: rtl/boreal_vec_seq.sv
// Purpose: per-lane MAC sequencer; turns a dot-product command into ZERO_ACC, N MACs, optional SCALE/CLAMP.
// Latency: command handshake in cycle 0 -> res_valid in cycle len+3+do_scale+do_clamp (no operand stalls).
// Backpressure: operand stalls freeze the lane (lane_en=0); result held until res_ready, cmd_ready low while busy.
//
// Ports: clk/rst_n (async active-low); cmd_* command channel (valid/ready, params latched at accept);
//        opnd_* int8 operand-pair stream (valid/ready); lane_* control/operands to the SIMD lane,
//        lane_acc accumulator feedback; res_* captured result (valid/ready); busy; perf_stall_cycles.
// Optional: BOREAL_VEC_SEQ_PERF_EN builds the saturating operand-stall counter; otherwise it reads 0.
module boreal_vec_seq #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_do_scale,
    input  logic             cmd_do_clamp,
    input  logic [15:0]      cmd_scale,
    input  logic [15:0]      cmd_zero_pt,
    input  logic [31:0]      cmd_clamp_min,
    input  logic [31:0]      cmd_clamp_max,
    input  logic             opnd_valid,
    output logic             opnd_ready,
    input  logic [7:0]       opnd_a,
    input  logic [7:0]       opnd_b,
    output logic             lane_en,
    output logic [2:0]       lane_op,
    output logic [7:0]       lane_a,
    output logic [7:0]       lane_b,
    output logic [15:0]      lane_scale,
    output logic [15:0]      lane_zero_pt,
    output logic [31:0]      lane_clamp_min,
    output logic [31:0]      lane_clamp_max,
    input  logic [31:0]      lane_acc,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             busy,
    output logic [31:0]      perf_stall_cycles
);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MAC   = 3'd1;
    localparam logic [2:0] OP_SCALE = 3'd2;
    localparam logic [2:0] OP_CLAMP = 3'd3;
    localparam logic [2:0] OP_ZERO  = 3'd5;

    // POST is split into SCALE and CLAMP states so a skipped op costs no cycle.
    typedef enum logic [2:0] {
        S_IDLE, S_ZERO, S_MAC, S_SCALE, S_CLAMP, S_WAIT, S_OUT
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q;
    logic               do_scale_q, do_clamp_q;
    logic [15:0]        scale_q, zero_pt_q;
    logic [31:0]        clamp_min_q, clamp_max_q;
    logic               res_valid_q;
    logic [31:0]        res_data_q;
    logic               cmd_hs;
    state_t             post_first;

    assign cmd_hs = (state_q == S_IDLE) && cmd_valid;

    // First post-accumulate state; falls through to WAIT when no post op is enabled.
    assign post_first = do_scale_q ? S_SCALE : (do_clamp_q ? S_CLAMP : S_WAIT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_valid) state_d = S_ZERO;
            S_ZERO:  state_d = (cnt_q != '0) ? S_MAC : post_first;
            S_MAC:   if (opnd_valid && (cnt_q == LEN_W'(1))) state_d = post_first;
            S_SCALE: state_d = do_clamp_q ? S_CLAMP : S_WAIT;
            S_CLAMP: state_d = S_WAIT;
            S_WAIT:  state_d = S_OUT;
            S_OUT:   if (res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            do_scale_q  <= 1'b0;
            do_clamp_q  <= 1'b0;
            scale_q     <= '0;
            zero_pt_q   <= '0;
            clamp_min_q <= '0;
            clamp_max_q <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (cmd_hs) begin
                cnt_q       <= cmd_len;
                do_scale_q  <= cmd_do_scale;
                do_clamp_q  <= cmd_do_clamp;
                scale_q     <= cmd_scale;
                zero_pt_q   <= cmd_zero_pt;
                clamp_min_q <= cmd_clamp_min;
                clamp_max_q <= cmd_clamp_max;
            end
            if ((state_q == S_MAC) && opnd_valid) begin
                cnt_q <= cnt_q - LEN_W'(1);
            end
            // The last issued op has landed in lane_acc by the WAIT cycle.
            if (state_q == S_WAIT) begin
                res_data_q  <= lane_acc;
                res_valid_q <= 1'b1;
            end
            if ((state_q == S_OUT) && res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        lane_en = 1'b0;
        lane_op = OP_NOP;
        case (state_q)
            S_ZERO: begin
                lane_en = 1'b1;
                lane_op = OP_ZERO;
            end
            S_MAC: begin
                // Lane only advances on an operand handshake.
                lane_en = opnd_valid;
                lane_op = opnd_valid ? OP_MAC : OP_NOP;
            end
            S_SCALE: begin
                lane_en = 1'b1;
                lane_op = OP_SCALE;
            end
            S_CLAMP: begin
                lane_en = 1'b1;
                lane_op = OP_CLAMP;
            end
            default: begin
                lane_en = 1'b0;
                lane_op = OP_NOP;
            end
        endcase
    end

    assign opnd_ready     = (state_q == S_MAC);
    assign lane_a         = (state_q == S_MAC) ? opnd_a : 8'd0;
    assign lane_b         = (state_q == S_MAC) ? opnd_b : 8'd0;
    assign lane_scale     = scale_q;
    assign lane_zero_pt   = zero_pt_q;
    assign lane_clamp_min = clamp_min_q;
    assign lane_clamp_max = clamp_max_q;
    assign cmd_ready      = (state_q == S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;

`ifdef BOREAL_VEC_SEQ_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (cmd_hs) begin
            perf_q <= '0;
        end else if ((state_q == S_MAC) && !opnd_valid && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_q;
`else
    assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_boreal_vec_seq.sv
module tb_boreal_vec_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [15:0] cmd_len;
    logic        cmd_do_scale, cmd_do_clamp;
    logic [15:0] cmd_scale, cmd_zero_pt;
    logic [31:0] cmd_clamp_min, cmd_clamp_max;
    logic        opnd_valid, opnd_ready;
    logic [7:0]  opnd_a, opnd_b;
    logic        lane_en;
    logic [2:0]  lane_op;
    logic [7:0]  lane_a, lane_b;
    logic [15:0] lane_scale, lane_zero_pt;
    logic [31:0] lane_clamp_min, lane_clamp_max;
    logic [31:0] lane_acc;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic        busy;
    logic [31:0] perf_stall_cycles;

    always #5 clk = ~clk;

    boreal_vec_seq #(.LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_do_scale(cmd_do_scale), .cmd_do_clamp(cmd_do_clamp),
        .cmd_scale(cmd_scale), .cmd_zero_pt(cmd_zero_pt),
        .cmd_clamp_min(cmd_clamp_min), .cmd_clamp_max(cmd_clamp_max),
        .opnd_valid(opnd_valid), .opnd_ready(opnd_ready), .opnd_a(opnd_a), .opnd_b(opnd_b),
        .lane_en(lane_en), .lane_op(lane_op), .lane_a(lane_a), .lane_b(lane_b),
        .lane_scale(lane_scale), .lane_zero_pt(lane_zero_pt),
        .lane_clamp_min(lane_clamp_min), .lane_clamp_max(lane_clamp_max),
        .lane_acc(lane_acc),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .perf_stall_cycles(perf_stall_cycles)
    );

    // ---------------- behavioural SIMD lane ----------------
    function automatic int mac_fn(int acc, logic [7:0] a, logic [7:0] b);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return acc + sa * sb;
    endfunction

    function automatic int scale_fn(int acc, logic [15:0] sc, logic [15:0] zp);
        longint p;
        p = longint'(acc) * longint'({16'd0, sc});
        return int'(p >>> 16) + int'($signed(zp));
    endfunction

    function automatic int clamp_fn(int acc, int lo, int hi);
        if (acc < lo) return lo;
        if (acc > hi) return hi;
        return acc;
    endfunction

    int acc_m;
    assign lane_acc = acc_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_m <= 0;
        else if (lane_en) begin
            case (lane_op)
                3'd5: acc_m <= 0;
                3'd1: acc_m <= mac_fn(acc_m, lane_a, lane_b);
                3'd2: acc_m <= scale_fn(acc_m, lane_scale, lane_zero_pt);
                3'd3: acc_m <= clamp_fn(acc_m, int'(lane_clamp_min), int'(lane_clamp_max));
                default: acc_m <= acc_m;
            endcase
        end
    end

    // Log of issued lane ops and stall-time enable violations.
    int op_log[$];
    int stall_viol;
    always @(negedge clk) begin
        if (lane_en) op_log.push_back(int'(lane_op));
        if (opnd_ready && !opnd_valid && lane_en) stall_viol++;
    end

    // ---------------- checking infrastructure ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name,
                     $signed(act), act, $signed(exp), exp);
        end
    endtask

    typedef struct {
        int          len;
        bit          sc;
        bit          cl;
        logic [15:0] scale;
        logic [15:0] zp;
        int          cmin;
        int          cmax;
        logic [63:0] a_pk;     // beat k in bits [8k+7:8k]
        logic [63:0] b_pk;
        int          gap_after;
        int          gap;
        int          hold;
        int          exp_data;
        int          exp_cyc;
    } vec_t;

    function automatic vec_t mk(int len, bit sc, bit cl, logic [15:0] scale, logic [15:0] zp,
                                int cmin, int cmax, logic [63:0] a, logic [63:0] b,
                                int gap_after, int gap, int hold, int exp_data, int exp_cyc);
        vec_t v;
        v.len = len; v.sc = sc; v.cl = cl; v.scale = scale; v.zp = zp;
        v.cmin = cmin; v.cmax = cmax; v.a_pk = a; v.b_pk = b;
        v.gap_after = gap_after; v.gap = gap; v.hold = hold;
        v.exp_data = exp_data; v.exp_cyc = exp_cyc;
        return v;
    endfunction

    task automatic run_vec(input string tag, input vec_t v);
        int  n;
        bit  got;
        int  k;
        int  gcnt;
        int  exp_ops[$];
        bit  ok;
        int  exp_perf;
        int  exp_d;
        op_log.delete();
        stall_viol = 0;
        @(negedge clk);
        chk({tag, ".cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_len       = 16'(v.len);
        cmd_do_scale  = v.sc;
        cmd_do_clamp  = v.cl;
        cmd_scale     = v.scale;
        cmd_zero_pt   = v.zp;
        cmd_clamp_min = v.cmin;
        cmd_clamp_max = v.cmax;
        cmd_valid     = 1'b1;
        sb_q.push_back(v.exp_data);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 1;
        got = 1'b0;
        fork
            begin
                k = 0;
                gcnt = 0;
                for (int c = 0; c < 400 && k < v.len; c++) begin
                    @(negedge clk);
                    if (k == v.gap_after && gcnt < v.gap && opnd_ready) begin
                        opnd_valid = 1'b0;
                        gcnt++;
                    end else begin
                        opnd_valid = 1'b1;
                        opnd_a = v.a_pk[8*k +: 8];
                        opnd_b = v.b_pk[8*k +: 8];
                        if (opnd_ready) k++;
                    end
                end
                @(negedge clk);
                opnd_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 400 && !got; c++) begin
                    @(negedge clk);
                    if (res_valid) got = 1'b1;
                    else n++;
                end
            end
        join
        if (!got) begin
            chk({tag, ".res_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, ".latency"}, 32'(n), 32'(v.exp_cyc));
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
            exp_d = 0;
        end else begin
            exp_d = sb_q.pop_front();
        end
        chk({tag, ".res_data"}, res_data, exp_d);
        exp_ops.push_back(5);
        for (int i = 0; i < v.len; i++) exp_ops.push_back(1);
        if (v.sc) exp_ops.push_back(2);
        if (v.cl) exp_ops.push_back(3);
        ok = (exp_ops.size() == op_log.size());
        if (ok) for (int i = 0; i < exp_ops.size(); i++) if (exp_ops[i] != op_log[i]) ok = 1'b0;
        chk({tag, ".op_seq_ok"}, 32'(ok), 32'd1);
        chk({tag, ".stall_en_viol"}, 32'(stall_viol), 32'd0);
        chk({tag, ".lane_scale"}, 32'(lane_scale), 32'(v.scale));
        chk({tag, ".lane_clamp_min"}, lane_clamp_min, v.cmin);
`ifdef BOREAL_VEC_SEQ_PERF_EN
        exp_perf = v.gap;
`else
        exp_perf = 0;
`endif
        chk({tag, ".perf_stall"}, perf_stall_cycles, exp_perf);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(res_valid), 32'd1);
            chk({tag, ".hold_data"}, res_data, exp_d);
            chk({tag, ".hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        chk({tag, ".post_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, ".post_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, ".post_busy"}, 32'(busy), 32'd0);
    endtask

    vec_t tbl[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats;
        // 3 beats: (2,3),(-1,4),(5,5) -> 27
        tbl[0] = mk(3, 0, 0, 16'h0000, 16'h0000, 0, 0, 64'h05FF02, 64'h050403, 0, 0, 0, 27, 6);
        tbl[1] = mk(3, 1, 0, 16'h8000, 16'h0000, 0, 0, 64'h05FF02, 64'h050403, 0, 0, 0, 13, 7);
        tbl[2] = mk(3, 0, 1, 16'h0000, 16'h0000, -10, 10, 64'h05FF02, 64'h050403, 0, 0, 0, 10, 7);
        tbl[3] = mk(3, 0, 1, 16'h0000, 16'h0000, -10, 100, 64'h05FF02, 64'h050403, 0, 0, 0, 27, 7);
        tbl[4] = mk(3, 0, 0, 16'h0000, 16'h0000, 0, 0, 64'h05FF02, 64'h050403, 1, 4, 0, 27, 10);
        // scale 0x10000 truncated to 16 bits is 0x0000; result is just the zero point
        tbl[5] = mk(0, 1, 0, 16'h0000, 16'h0005, 0, 0, 64'h0, 64'h0, 0, 0, 5, 5, 4);
        tbl[6] = mk(3, 1, 1, 16'h8000, 16'h0000, -10, 10, 64'h05FF02, 64'h050403, 0, 0, 0, 10, 8);
        // (-3,7),(-2,5) -> -31, clamped to -10
        tbl[7] = mk(2, 0, 1, 16'h0000, 16'h0000, -10, 10, 64'hFEFD, 64'h0507, 0, 0, 0, -10, 6);
        tbl[8] = mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 64'h03, 64'h03, 0, 0, 0, 9, 4);

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_len = '0; cmd_do_scale = 1'b0; cmd_do_clamp = 1'b0;
        cmd_scale = '0; cmd_zero_pt = '0; cmd_clamp_min = '0; cmd_clamp_max = '0;
        opnd_valid = 1'b0; opnd_a = '0; opnd_b = '0; res_ready = 1'b0;
        #7;
        chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst.opnd_ready", 32'(opnd_ready), 32'd0);
        chk("rst.lane_en", 32'(lane_en), 32'd0);
        chk("rst.lane_op", 32'(lane_op), 32'd0);
        chk("rst.lane_ab", {16'd0, lane_a, lane_b}, 32'd0);
        chk("rst.lane_scale_zp", {lane_scale, lane_zero_pt}, 32'd0);
        chk("rst.lane_clamp_min", lane_clamp_min, 32'd0);
        chk("rst.lane_clamp_max", lane_clamp_max, 32'd0);
        chk("rst.res_valid", 32'(res_valid), 32'd0);
        chk("rst.res_data", res_data, 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.perf", perf_stall_cycles, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        // Reset mid-MAC after two beats of a len=8 command.
        @(negedge clk);
        cmd_len = 16'd8; cmd_do_scale = 1'b1; cmd_do_clamp = 1'b1;
        cmd_scale = 16'h1234; cmd_zero_pt = 16'h0007;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        beats = 0;
        opnd_valid = 1'b1; opnd_a = 8'd1; opnd_b = 8'd1;
        for (int c = 0; c < 50 && beats < 2; c++) begin
            @(negedge clk);
            if (opnd_ready) beats++;
        end
        chk("midrst.beats_taken", 32'(beats), 32'd2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.res_valid", 32'(res_valid), 32'd0);
        chk("midrst.lane_en", 32'(lane_en), 32'd0);
        chk("midrst.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("midrst.lane_scale", 32'(lane_scale), 32'd0);
        opnd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("after_rst", tbl[8]);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/boreal_vec_seq.md
Name: boreal_vec_seq

Overview:
Per-lane MAC sequencer that sits directly upstream of the SIMD vector lane. It accepts a dot-product command, issues ZERO_ACC, then N MAC ops fed from an operand stream, then optional SCALE and CLAMP ops. It captures the lane accumulator and presents it on a valid/ready result port. It is the only driver of the lane's control and operand inputs.

Parameters:
LEN_W, 16, width of the command length field. Maximum dot-product length is 2^LEN_W-1.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_len  in  LEN_W  number of operand pairs (MAC beats)
cmd_do_scale  in  1  issue the SCALE op after the MACs
cmd_do_clamp  in  1  issue the CLAMP op after SCALE
cmd_scale  in  16  requant scale, latched at command accept
cmd_zero_pt  in  16  requant zero point, latched
cmd_clamp_min  in  32  signed clamp minimum, latched
cmd_clamp_max  in  32  signed clamp maximum, latched
opnd_valid  in  1  operand pair offered
opnd_ready  out  1  operand pair consumed when opnd_valid & opnd_ready
opnd_a  in  8  int8 operand A
opnd_b  in  8  int8 operand B
lane_en  out  1  lane enable
lane_op  out  3  lane opcode: 0 NOP, 1 MAC, 2 SCALE, 3 CLAMP, 5 ZERO_ACC
lane_a  out  8  lane operand A
lane_b  out  8  lane operand B
lane_scale  out  16  latched cmd_scale
lane_zero_pt  out  16  latched cmd_zero_pt
lane_clamp_min  out  32  latched cmd_clamp_min
lane_clamp_max  out  32  latched cmd_clamp_max
lane_acc  in  32  lane accumulator; reflects an op one cycle after it is issued
res_valid  out  1  result available
res_ready  in  1  result consumed when res_valid & res_ready
res_data  out  32  captured accumulator
busy  out  1  high in every state except IDLE
perf_stall_cycles  out  32  operand-stall counter (see Optional Feature)

Behaviour:
- Reset values:
  - State is IDLE.
  - cmd_ready=1.
  - opnd_ready=0, lane_en=0, lane_op=0, lane_a=0, lane_b=0.
  - All latched parameter outputs are 0.
  - res_valid=0, res_data=0, busy=0, perf_stall_cycles=0.
- All lane_* outputs and opnd_ready are combinational from state and registers. opnd_a and opnd_b pass straight through to lane_a and lane_b.
- IDLE:
  - cmd_ready=1.
  - On handshake: latch the len, flag and parameter fields, set the beat counter to cmd_len, and go to ZERO.
- ZERO (1 cycle):
  - lane_en=1, lane_op=5.
  - Go to MAC if len is non-zero; otherwise go to POST.
- MAC:
  - opnd_ready=1.
  - lane_op=1 and lane_en=opnd_valid, so the lane only advances on an operand handshake.
  - No valid operand (stall): lane_en=0 and lane_op=0.
  - Each handshake decrements the counter. The handshake on which the counter reaches 0 moves to POST.
- POST:
  - Issues SCALE (lane_en=1, op=2) for one cycle if do_scale is set.
  - Then issues CLAMP (op=3) for one cycle if do_clamp is set.
  - Skipped ops take no cycle. After the last issued op, go to WAIT.
- WAIT (1 cycle):
  - lane_en=0.
  - res_data<=lane_acc, res_valid<=1, go to OUT.
- OUT:
  - res_valid and res_data are held stable until res_ready.
  - On handshake: res_valid<=0, go to IDLE. cmd_ready is high again the next cycle.
  - No bypass: a new command is never accepted in the same cycle as the result handshake.
- Latency with no stalls: command handshake in cycle 0 gives res_valid high in cycle len+3+do_scale+do_clamp.
- cmd_len=0: result is ZERO_ACC followed by the enabled post ops.
- Reset asserted mid-operation: everything returns to reset values immediately.
  - A partially consumed operand stream is not drained; the upstream producer must also be reset.
- The counter is exactly LEN_W bits. A maximum-length command performs exactly 2^LEN_W-1 MACs with no wrap.

Optional Feature:
BOREAL_VEC_SEQ_PERF_EN
- Defined:
  - perf_stall_cycles increments by 1 every cycle the block is in MAC with opnd_valid=0.
  - It saturates at 0xFFFFFFFF and clears to 0 on each command accept.
- Undefined: perf_stall_cycles is tied to 0 and no counter logic is built.

Test Plan:
- len=3, pairs (2,3),(-1,4),(5,5), no scale, no clamp, opnd_valid always high -> lane ops 5,1,1,1; res_data=27; res_valid first high in cycle 6.
- Same operands with do_scale=1, scale=0x8000, zero_pt=0 -> res_data=13; res_valid in cycle 7.
- Same operands with do_clamp=1, clamp_min=-10, clamp_max=10 -> res_data=10; with min=-10, max=100 -> res_data=27.
- len=3 with opnd_valid low for 4 cycles between beats 1 and 2 -> lane_en=0 during the gap; res_data=27; res_valid in cycle 10; with PERF_EN, perf_stall_cycles=4.
- len=0, do_scale=1, scale=0x10000 truncated to 16 bits (0x0000), zero_pt=5 -> res_data=5. Hold res_ready=0 for 5 cycles -> res_data stable and cmd_ready=0 throughout.
- Assert rst_n low mid-MAC after 2 beats of a len=8 command -> busy=0, res_valid=0, lane_en=0 immediately. A fresh len=1 (3,3) command afterwards -> res_data=9.
